fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and load-use interlock unit for the pipelined core. Replaces the per-operand hazard mux chains in the execute stage. It tracks every in-flight register write in a DEPTH-slot shift register and, for NRD source operands of the instruction being issued into EX, selects the youngest ready producer or the register-file value. If the youngest producer's data is not ready yet, it raises a stall. It adds condition-fail cancellation, PC exclusion and a saturating stall counter.

---
 rtl/fwd_scoreboard_pkg.sv | 19 +
 rtl/fwd_scoreboard_match.sv | 40 ++++
 rtl/fwd_scoreboard.sv | 111 +++++++++++
 tb/tb_fwd_scoreboard.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants and helpers for the operand-forwarding scoreboard.
package fwd_scoreboard_pkg;

   localparam int DEF_REGAW = 4;
   localparam int DEF_FULLW = 32;
   localparam int DEF_PC_I  = 15;

   // Width of a slot index; a single-slot scoreboard still needs one bit.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // A producer in slot k can forward once it has reached its ready slot.
   function automatic logic slot_ready(input int k, input logic is_load,
                                       input int alu_ready, input int load_ready);
      return (k >= (is_load ? load_ready : alu_ready));
   endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Priority search of the in-flight slots for one source operand.
module fwd_match
   import fwd_scoreboard_pkg::*;
#(
   parameter int REGAW      = DEF_REGAW,
   parameter int DEPTH      = 3,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 2,
   parameter int PC_IDX     = DEF_PC_I,
   parameter int IDXW       = idx_width(DEPTH)
) (
   input  logic [DEPTH-1:0]       slot_valid,
   input  logic [DEPTH-1:0]       slot_load,
   input  logic [DEPTH*REGAW-1:0] slot_addr,
   input  logic [REGAW-1:0]       src_addr,
   input  logic                   src_used,
   input  logic                   ex_cancel,
   output logic                   hit,
   output logic [IDXW-1:0]        slot_idx,
   output logic                   ready
);

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit      = 1'b0;
      slot_idx = '0;
      ready    = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (slot_valid[k] && src_used &&
             (slot_addr[k*REGAW +: REGAW] == src_addr) &&
             (src_addr != REGAW'(PC_IDX)) &&
             !((k == 0) && ex_cancel)) begin
            hit      = 1'b1;
            slot_idx = IDXW'(k);
            ready    = slot_ready(k, slot_load[k], ALU_READY, LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and load-use interlock for the execute stage.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int REGAW      = DEF_REGAW,
   parameter int DATAW      = DEF_FULLW,
   parameter int NRD        = 3,
   parameter int DEPTH      = 3,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 2,
   parameter int PC_IDX     = DEF_PC_I
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   issue_valid,
   input  logic                   issue_kill,
   input  logic                   issue_wr_en,
   input  logic [REGAW-1:0]       issue_wr_addr,
   input  logic                   issue_is_load,
   input  logic [NRD*REGAW-1:0]   src_addr,
   input  logic [NRD-1:0]         src_used,
   input  logic [NRD*DATAW-1:0]   rf_data,
   input  logic [DEPTH*DATAW-1:0] stage_data,
   input  logic                   ex_cancel,
   output logic                   stall,
   output logic [NRD*DATAW-1:0]   op_data,
   output logic [15:0]            stall_count
);

   localparam int IDXW = idx_width(DEPTH);

   logic [DEPTH-1:0]       slot_valid;
   logic [DEPTH-1:0]       slot_load;
   logic [DEPTH*REGAW-1:0] slot_addr;
   logic [NRD-1:0]         hit;
   logic [NRD-1:0]         ready;
   logic [NRD*IDXW-1:0]    slot_idx;
   logic                   any_block;
   logic                   accept;

   for (genvar p = 0; p < NRD; p++) begin : g_port
      fwd_match #(
         .REGAW      (REGAW),
         .DEPTH      (DEPTH),
         .ALU_READY  (ALU_READY),
         .LOAD_READY (LOAD_READY),
         .PC_IDX     (PC_IDX),
         .IDXW       (IDXW)
      ) u_match (
         .slot_valid (slot_valid),
         .slot_load  (slot_load),
         .slot_addr  (slot_addr),
         .src_addr   (src_addr[p*REGAW +: REGAW]),
         .src_used   (src_used[p]),
         .ex_cancel  (ex_cancel),
         .hit        (hit[p]),
         .slot_idx   (slot_idx[p*IDXW +: IDXW]),
         .ready      (ready[p])
      );
   end

   // Stall if any port's youngest producer is not ready; a killed issue never stalls.
   always_comb begin
      any_block = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         if (hit[p] && !ready[p]) any_block = 1'b1;
      end
      stall  = issue_valid & ~issue_kill & any_block;
      accept = issue_valid & ~issue_kill & ~any_block;
   end

   // Operand mux: forwarded slot data on a ready hit, register file otherwise.
   always_comb begin
      op_data = rf_data;
      for (int p = 0; p < NRD; p++) begin
         if (!stall && hit[p] && ready[p]) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (slot_idx[p*IDXW +: IDXW] == IDXW'(k))
                  op_data[p*DATAW +: DATAW] = stage_data[k*DATAW +: DATAW];
            end
         end
      end
   end

   // Slots advance every cycle; a cancelled slot-0 instruction leaves as a dead entry.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         slot_valid <= '0;
         slot_load  <= '0;
         slot_addr  <= '0;
      end else begin
         slot_valid[0]         <= accept & issue_wr_en;
         slot_load[0]          <= issue_is_load;
         slot_addr[0 +: REGAW] <= issue_wr_addr;
         for (int k = 1; k < DEPTH; k++) begin
            slot_valid[k]             <= slot_valid[k-1] & ~((k == 1) & ex_cancel);
            slot_load[k]              <= slot_load[k-1];
            slot_addr[k*REGAW +: REGAW] <= slot_addr[(k-1)*REGAW +: REGAW];
         end
      end
   end

   // Saturating count of cycles in which issue was held off.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         stall_count <= '0;
      else if (stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed table, random vs. model, saturation.
module tb_fwd_scoreboard;

   localparam int REGAW      = 4;
   localparam int DATAW      = 32;
   localparam int NRD        = 3;
   localparam int DEPTH      = 3;
   localparam int ALU_READY  = 1;
   localparam int LOAD_READY = 2;
   localparam int PC_IDX     = 15;
   localparam int SAT_DEPTH  = 32;

   localparam logic [95:0] RF  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
   localparam logic [95:0] ST0 = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};

   logic        clk;
   logic        nreset;
   logic        issue_valid, issue_kill, issue_wr_en, issue_is_load, ex_cancel;
   logic [3:0]  issue_wr_addr;
   logic [11:0] src_addr;
   logic [2:0]  src_used;
   logic [95:0] rf_data, stage_data;
   logic        stall;
   logic [95:0] op_data;
   logic [15:0] stall_count;

   logic        sat_nreset;
   logic        sat_stall;
   logic [95:0] sat_op;
   logic [15:0] sat_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          valid, kill, wr_en, is_load, cancel;
      logic [3:0]  wr_addr;
      logic [11:0] src;
      logic [2:0]  used;
      logic [95:0] rf, stage;
      bit          exp_stall;
      logic [95:0] exp_op;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct {
      bit       valid;
      bit [3:0] addr;
      bit       is_load;
   } ent_t;

   ent_t inflight[$];
   int   model_count;
   vec_t table_v[$];

   fwd_scoreboard #(
      .REGAW(REGAW), .DATAW(DATAW), .NRD(NRD), .DEPTH(DEPTH),
      .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .PC_IDX(PC_IDX)
   ) dut (
      .clk(clk), .nreset(nreset),
      .issue_valid(issue_valid), .issue_kill(issue_kill),
      .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
      .issue_is_load(issue_is_load), .src_addr(src_addr),
      .src_used(src_used), .rf_data(rf_data), .stage_data(stage_data),
      .ex_cancel(ex_cancel), .stall(stall), .op_data(op_data),
      .stall_count(stall_count)
   );

   // Deep scoreboard that keeps one load in flight long enough to stall almost every cycle.
   fwd_scoreboard #(
      .REGAW(REGAW), .DATAW(DATAW), .NRD(NRD), .DEPTH(SAT_DEPTH),
      .ALU_READY(1), .LOAD_READY(SAT_DEPTH - 1), .PC_IDX(PC_IDX)
   ) dut_sat (
      .clk(clk), .nreset(sat_nreset),
      .issue_valid(1'b1), .issue_kill(1'b0),
      .issue_wr_en(1'b1), .issue_wr_addr(4'd5),
      .issue_is_load(1'b1), .src_addr({3{4'd5}}),
      .src_used(3'b111), .rf_data(rf_data), .stage_data('0),
      .ex_cancel(1'b0), .stall(sat_stall), .op_data(sat_op),
      .stall_count(sat_count)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(bit valid, bit kill, bit wr_en, logic [3:0] wr, bit ld,
                               logic [11:0] src, logic [2:0] used, bit cancel,
                               logic [95:0] stage, bit es, logic [95:0] eo, logic [15:0] ec);
      vec_t v;
      v.valid = valid; v.kill = kill; v.wr_en = wr_en; v.wr_addr = wr; v.is_load = ld;
      v.src = src; v.used = used; v.cancel = cancel; v.rf = RF; v.stage = stage;
      v.exp_stall = es; v.exp_op = eo; v.exp_cnt = ec;
      return v;
   endfunction

   function automatic logic [3:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(1, 3));
   endfunction

   task automatic applyStimulus(input vec_t v);
      issue_valid   = v.valid;
      issue_kill    = v.kill;
      issue_wr_en   = v.wr_en;
      issue_wr_addr = v.wr_addr;
      issue_is_load = v.is_load;
      src_addr      = v.src;
      src_used      = v.used;
      ex_cancel     = v.cancel;
      rf_data       = v.rf;
      stage_data    = v.stage;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      inflight.delete();
      for (int i = 0; i < DEPTH; i++) inflight.push_back('{1'b0, 4'd0, 1'b0});
      model_count = 0;
   endtask

   // Reference: age 0 is the youngest write; the youngest matching write decides each port.
   function automatic void model_eval(output bit es, output logic [95:0] eo);
      bit blocked = 1'b0;
      eo = rf_data;
      for (int p = 0; p < NRD; p++) begin
         bit found = 1'b0;
         logic [3:0] a = src_addr[p*4 +: 4];
         for (int age = 0; age < DEPTH; age++) begin
            if (!found && inflight[age].valid && src_used[p] && inflight[age].addr == a &&
                a != 4'(PC_IDX) && !(age == 0 && ex_cancel)) begin
               found = 1'b1;
               if (age >= (inflight[age].is_load ? LOAD_READY : ALU_READY))
                  eo[p*32 +: 32] = stage_data[age*32 +: 32];
               else
                  blocked = 1'b1;
            end
         end
      end
      es = issue_valid && !issue_kill && blocked;
      if (es) eo = rf_data;
   endfunction

   task automatic model_step(input bit es);
      bit acc = issue_valid && !issue_kill && !es;
      if (ex_cancel) inflight[0].valid = 1'b0;
      inflight.push_front('{acc && issue_wr_en, issue_wr_addr, issue_is_load});
      void'(inflight.pop_back());
      if (es && model_count < 65535) model_count++;
   endtask

   initial begin
      vec_t v;
      bit es;
      logic [95:0] eo;
      int c, expc;

      nreset = 1'b0;
      sat_nreset = 1'b0;
      applyStimulus(mk(0,0,0,0,0,0,0,0,ST0,0,RF,0));

      // Reset held with random inputs: idle outputs.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         v = mk($urandom_range(0,1), 0, 1, rnd_addr(), $urandom_range(0,1),
                {rnd_addr(), rnd_addr(), rnd_addr()}, 3'($urandom_range(0,7)), 0,
                {$urandom, $urandom, $urandom}, 0, RF, 0);
         v.rf = {$urandom, $urandom, $urandom};
         applyStimulus(v);
         #1;
         checkOutput($sformatf("rst%0d stall", i), {31'b0, stall}, 32'd0);
         checkOutput($sformatf("rst%0d op0", i), op_data[31:0], v.rf[31:0]);
         checkOutput($sformatf("rst%0d op2", i), op_data[95:64], v.rf[95:64]);
         checkOutput($sformatf("rst%0d cnt", i), {16'b0, stall_count}, 32'd0);
      end
      applyStimulus(mk(0,0,0,0,0,0,0,0,ST0,0,RF,0));
      nreset = 1'b1;

      // Directed sequence; pipeline state carries from one row to the next.
      table_v.push_back(mk(1,0,1,4'd1,0,{4'd0,4'd0,4'd1},3'b001,0,ST0,0,RF,0));
      table_v.push_back(mk(1,0,1,4'd6,0,{4'd3,4'd2,4'd1},3'b001,0,ST0,1,RF,0));
      table_v.push_back(mk(1,0,1,4'd6,0,{4'd3,4'd2,4'd1},3'b001,0,
                           {32'hC02,32'h5,32'hC00},0,{RF[95:32],32'h0000_0005},1));
      table_v.push_back(mk(1,0,1,4'd2,1,12'h0,3'b000,0,ST0,0,RF,1));
      table_v.push_back(mk(1,0,0,4'd0,0,12'h0,3'b000,0,ST0,0,RF,1));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd2,4'd0},3'b010,0,ST0,1,RF,1));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd2,4'd0},3'b010,0,
                           {32'hDEAD_BEEF,32'hC01,32'hC00},0,{RF[95:64],32'hDEAD_BEEF,RF[31:0]},2));
      table_v.push_back(mk(1,0,1,4'd3,0,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,1,4'd3,0,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd3,4'd0,4'd3},3'b101,0,
                           {32'h11,32'h22,32'h33},0,{32'h22,RF[63:32],32'h22},2));
      table_v.push_back(mk(1,0,1,4'd4,1,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd0,4'd4},3'b001,1,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd0,4'd4},3'b001,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,1,4'd15,0,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd15,4'd0},3'b010,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd15,4'd0},3'b010,0,
                           {32'hC02,32'h77,32'hC00},0,RF,2));
      table_v.push_back(mk(1,0,1,4'd7,0,12'h0,3'b000,0,ST0,0,RF,2));
      table_v.push_back(mk(1,1,1,4'd7,0,{4'd0,4'd0,4'd7},3'b001,0,ST0,0,RF,2));
      table_v.push_back(mk(1,0,0,4'd0,0,{4'd0,4'd0,4'd7},3'b001,0,
                           {32'hC02,32'h99,32'hC00},0,{RF[95:32],32'h99},2));

      foreach (table_v[i]) begin
         @(negedge clk);
         applyStimulus(table_v[i]);
         #1;
         checkOutput($sformatf("T%0d stall", i), {31'b0, stall}, {31'b0, table_v[i].exp_stall});
         for (int p = 0; p < NRD; p++)
            checkOutput($sformatf("T%0d op%0d", i, p), op_data[p*32 +: 32], table_v[i].exp_op[p*32 +: 32]);
         checkOutput($sformatf("T%0d cnt", i), {16'b0, stall_count}, {16'b0, table_v[i].exp_cnt});
      end

      // Random traffic against the reference model, with one mid-stream reset.
      @(negedge clk);
      nreset = 1'b0;
      model_reset();
      #1 nreset = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 200) begin
            nreset = 1'b0;
            model_reset();
         end
         v = mk($urandom_range(0,4) != 0, $urandom_range(0,9) == 0, $urandom_range(0,3) != 0,
                rnd_addr(), $urandom_range(0,4) < 2, {rnd_addr(), rnd_addr(), rnd_addr()},
                3'($urandom_range(0,7)), $urandom_range(0,6) == 0,
                {$urandom, $urandom, $urandom}, 0, RF, 0);
         v.rf = {$urandom, $urandom, $urandom};
         applyStimulus(v);
         #1;
         model_eval(es, eo);
         checkOutput($sformatf("R%0d stall", i), {31'b0, stall}, {31'b0, es});
         for (int p = 0; p < NRD; p++)
            checkOutput($sformatf("R%0d op%0d", i, p), op_data[p*32 +: 32], eo[p*32 +: 32]);
         checkOutput($sformatf("R%0d cnt", i), {16'b0, stall_count}, 32'(model_count));
         if (i == 200) nreset = 1'b1;
         @(posedge clk);
         model_step(es);
      end

      // Saturation: one accept then SAT_DEPTH-1 stalls, repeating.
      @(negedge clk);
      rf_data = RF;
      sat_nreset = 1'b1;
      #1;
      checkOutput("sat idle stall", {31'b0, sat_stall}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("sat first stall", {31'b0, sat_stall}, 32'd1);
      checkOutput("sat stalled op1", sat_op[63:32], RF[63:32]);
      c = 1;
      repeat (63999) @(posedge clk);
      c += 63999;
      #1;
      expc = c - (c + SAT_DEPTH - 1) / SAT_DEPTH;
      checkOutput("sat mid cnt", {16'b0, sat_count}, 32'(expc > 65535 ? 65535 : expc));
      repeat (3712) @(posedge clk);
      c += 3712;
      #1;
      expc = c - (c + SAT_DEPTH - 1) / SAT_DEPTH;
      checkOutput("sat final cnt", {16'b0, sat_count}, 32'(expc > 65535 ? 65535 : expc));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
